// File: rtl/mips_mux_pkg.sv
// Shared mux/arbiter definitions: source-choice modes and a one-hot to index helper.
package mips_mux_pkg;

  localparam int unsigned MUX_MODE_SELECT = 0;
  localparam int unsigned MUX_MODE_RR     = 1;

  localparam int unsigned MUX_MAX_INPUTS  = 16;
  localparam int unsigned MUX_IDX_BITS    = 4;

  // OR-reduction of set-bit positions; exact for a one-hot (or zero) input.
  function automatic logic [MUX_IDX_BITS-1:0] onehot_to_idx(
    input logic [MUX_MAX_INPUTS-1:0] onehot
  );
    logic [MUX_IDX_BITS-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MUX_MAX_INPUTS; i++) begin
      if (onehot[i]) begin
        idx = idx | MUX_IDX_BITS'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: ascending search from a rotating pointer, pointer moves past
// the winner only when the consumer accepts the grant.
module rr_arbiter
  import mips_mux_pkg::*;
#(
  parameter int unsigned NInputs = 4,
  parameter int unsigned SelBits = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NInputs-1:0] req,
  input  logic               advance,
  output logic [NInputs-1:0] grant,
  output logic [SelBits-1:0] grant_idx
);

  logic [SelBits-1:0] ptr_q;
  logic [SelBits-1:0] ptr_d;
  logic [SelBits-1:0] scan_idx;
  logic               found;

  // Walk all channels once starting at the pointer, wrapping explicitly at NInputs-1.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int unsigned k = 0; k < NInputs; k++) begin
      if (!found && req[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
      end
      scan_idx = (scan_idx == SelBits'(NInputs - 1)) ? '0 : scan_idx + SelBits'(1);
    end
  end

  assign grant_idx = SelBits'(onehot_to_idx(MUX_MAX_INPUTS'(grant)));

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (grant_idx == SelBits'(NInputs - 1)) ? '0 : grant_idx + SelBits'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/multiplexer_nto1_registered.sv
// N-to-1 registered datapath mux with stall/flush control; source chosen either by an
// explicit selector or by round-robin over valid requesters.
module multiplexer_nto1_registered
  import mips_mux_pkg::*;
#(
  parameter int unsigned NBits   = 32,
  parameter int unsigned NInputs = 4,
  parameter int unsigned SelBits = 2,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SelBits-1:0]       in_Selector,
  input  logic [NInputs-1:0]       in_Valid,
  input  logic [NInputs*NBits-1:0] MUX_Data_dw,
  input  logic                     in_Stall,
  input  logic                     in_Flush,
  output logic [NInputs-1:0]       out_Grant,
  output logic [NBits-1:0]         MUX_Output_dw,
  output logic                     out_Valid,
  output logic [SelBits-1:0]       out_Channel,
  output logic                     out_SelError
);

  logic               accept_en;
  logic [NInputs-1:0] grant_raw;
  logic [SelBits-1:0] win_idx;
  logic               has_grant;
  logic               sel_err;
  logic [NBits-1:0]   sel_data;

  assign accept_en = !in_Stall && !in_Flush;

  generate
    if (RR_MODE == MUX_MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^in_Selector;
      assign sel_err    = 1'b0;

      rr_arbiter #(
        .NInputs (NInputs),
        .SelBits (SelBits)
      ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (in_Valid),
        .advance   (accept_en),
        .grant     (grant_raw),
        .grant_idx (win_idx)
      );
    end else begin : g_sel
      logic sel_in_range;
      // Only reachable out of range when NInputs is not a power of two.
      assign sel_in_range = 32'(in_Selector) < NInputs;
      assign sel_err      = !sel_in_range;
      assign win_idx      = in_Selector;

      always_comb begin
        grant_raw = '0;
        for (int unsigned k = 0; k < NInputs; k++) begin
          if (in_Selector == SelBits'(k) && in_Valid[k]) begin
            grant_raw[k] = 1'b1;
          end
        end
      end
    end
  endgenerate

  assign has_grant = |grant_raw;
  assign out_Grant = (accept_en && reset) ? grant_raw : '0;

  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NInputs; k++) begin
      if (win_idx == SelBits'(k)) begin
        sel_data = MUX_Data_dw[k*NBits +: NBits];
      end
    end
  end

  // Flush beats stall; stall freezes everything including out_Valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MUX_Output_dw <= '0;
      out_Valid     <= 1'b0;
      out_Channel   <= '0;
      out_SelError  <= 1'b0;
    end else if (in_Flush) begin
      out_Valid    <= 1'b0;
      out_SelError <= 1'b0;
    end else if (!in_Stall) begin
      out_SelError <= sel_err;
      if (has_grant) begin
        MUX_Output_dw <= sel_data;
        out_Channel   <= win_idx;
        out_Valid     <= 1'b1;
      end else begin
        out_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multiplexer_nto1_registered.sv
// Directed bench: explicit-select (4 and 3 inputs) and round-robin (4 inputs) instances.
module tb_multiplexer_nto1_registered;

  logic clk;
  logic reset;

  logic [1:0]   a_sel;
  logic [3:0]   a_valid;
  logic [127:0] a_data;
  logic         a_stall, a_flush;
  logic [3:0]   a_grant;
  logic [31:0]  a_out;
  logic         a_vo;
  logic [1:0]   a_chan;
  logic         a_serr;

  logic [1:0]   b_sel;
  logic [3:0]   b_valid;
  logic [127:0] b_data;
  logic         b_stall, b_flush;
  logic [3:0]   b_grant;
  logic [31:0]  b_out;
  logic         b_vo;
  logic [1:0]   b_chan;
  logic         b_serr;

  logic [1:0]   c_sel;
  logic [2:0]   c_valid;
  logic [95:0]  c_data;
  logic         c_stall, c_flush;
  logic [2:0]   c_grant;
  logic [31:0]  c_out;
  logic         c_vo;
  logic [1:0]   c_chan;
  logic         c_serr;

  int checks   = 0;
  int failures = 0;

  multiplexer_nto1_registered #(.NBits(32), .NInputs(4), .SelBits(2), .RR_MODE(0)) u_sel4 (
    .clk(clk), .reset(reset), .in_Selector(a_sel), .in_Valid(a_valid), .MUX_Data_dw(a_data),
    .in_Stall(a_stall), .in_Flush(a_flush), .out_Grant(a_grant), .MUX_Output_dw(a_out),
    .out_Valid(a_vo), .out_Channel(a_chan), .out_SelError(a_serr));

  multiplexer_nto1_registered #(.NBits(32), .NInputs(4), .SelBits(2), .RR_MODE(1)) u_rr4 (
    .clk(clk), .reset(reset), .in_Selector(b_sel), .in_Valid(b_valid), .MUX_Data_dw(b_data),
    .in_Stall(b_stall), .in_Flush(b_flush), .out_Grant(b_grant), .MUX_Output_dw(b_out),
    .out_Valid(b_vo), .out_Channel(b_chan), .out_SelError(b_serr));

  multiplexer_nto1_registered #(.NBits(32), .NInputs(3), .SelBits(2), .RR_MODE(0)) u_sel3 (
    .clk(clk), .reset(reset), .in_Selector(c_sel), .in_Valid(c_valid), .MUX_Data_dw(c_data),
    .in_Stall(c_stall), .in_Flush(c_flush), .out_Grant(c_grant), .MUX_Output_dw(c_out),
    .out_Valid(c_vo), .out_Channel(c_chan), .out_SelError(c_serr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    a_sel = 2'd0; a_valid = 4'b0000; a_stall = 1'b0; a_flush = 1'b0;
    a_data  = {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000};
    b_sel = 2'd0; b_valid = 4'b1111; b_stall = 1'b0; b_flush = 1'b0;
    b_data  = {32'hB0000003, 32'hB0000002, 32'hB0000001, 32'hB0000000};
    c_sel = 2'd0; c_valid = 3'b000; c_stall = 1'b0; c_flush = 1'b0;
    c_data  = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};

    // Reset state, grant suppressed while reset is low
    #2;
    check("rst_a_out",   a_out, 32'h0);
    check("rst_a_valid", 32'(a_vo), 32'h0);
    check("rst_a_chan",  32'(a_chan), 32'h0);
    check("rst_a_serr",  32'(a_serr), 32'h0);
    check("rst_b_grant", 32'(b_grant), 32'h0);
    tick();
    tick();
    b_valid = 4'b0000;
    reset   = 1'b1;
    #1;

    // Test 1: explicit select of channel 2
    a_sel = 2'd2; a_valid = 4'b0100;
    #1;
    check("t1_grant", 32'(a_grant), 32'h4);
    tick();
    check("t1_out",   a_out, 32'hDEADBEEF);
    check("t1_chan",  32'(a_chan), 32'h2);
    check("t1_valid", 32'(a_vo), 32'h1);
    a_sel = 2'd1;
    #1;
    check("t1_nogrant", 32'(a_grant), 32'h0);
    tick();
    check("t1_valid_drop", 32'(a_vo), 32'h0);
    check("t1_out_hold",   a_out, 32'hDEADBEEF);
    a_sel = 2'd3; a_valid = 4'b1000;
    #1;
    check("t1_grant3", 32'(a_grant), 32'h8);
    tick();
    check("t1_out3", a_out, 32'h33333333);

    // Test 2: round-robin over all-valid
    b_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int e;
      e = i % 4;
      #1;
      check("t2_grant", 32'(b_grant), 32'(1) << e);
      tick();
      check("t2_chan",  32'(b_chan), 32'(e));
      check("t2_out",   b_out, 32'hB0000000 | 32'(e));
      check("t2_valid", 32'(b_vo), 32'h1);
    end

    // Move pointer from 1 to 3
    b_valid = 4'b0010;
    tick();
    b_valid = 4'b0100;
    tick();
    check("t3_pre_chan", 32'(b_chan), 32'h2);

    // Test 3: wrap from pointer 3
    b_valid = 4'b0101;
    #1;
    check("t3_grant_wrap", 32'(b_grant), 32'h1);
    tick();
    check("t3_chan0", 32'(b_chan), 32'h0);
    #1;
    check("t3_grant_next", 32'(b_grant), 32'h4);
    tick();
    check("t3_chan2", 32'(b_chan), 32'h2);

    // Test 4: stall freezes outputs and pointer (pointer now 3)
    b_valid = 4'b1111; b_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_grant", 32'(b_grant), 32'h0);
      tick();
      check("t4_chan",  32'(b_chan), 32'h2);
      check("t4_valid", 32'(b_vo), 32'h1);
      check("t4_out",   b_out, 32'hB0000002);
    end
    b_stall = 1'b0;
    #1;
    check("t4_resume", 32'(b_grant), 32'h8);
    tick();
    check("t4_chan3", 32'(b_chan), 32'h3);

    // Test 5: flush with stall while valid
    b_stall = 1'b1; b_flush = 1'b1;
    #1;
    check("t5_grant", 32'(b_grant), 32'h0);
    tick();
    check("t5_valid", 32'(b_vo), 32'h0);
    check("t5_out",   b_out, 32'hB0000003);
    check("t5_chan",  32'(b_chan), 32'h3);
    b_stall = 1'b0; b_flush = 1'b0;
    #1;
    check("t5_ptr_hold", 32'(b_grant), 32'h1);
    tick();
    tick();
    check("t5_chan1", 32'(b_chan), 32'h1);
    b_valid = 4'b0000;

    // Test 6: out-of-range selector on 3-input instance
    c_sel = 2'd3; c_valid = 3'b111;
    #1;
    check("t6_grant", 32'(c_grant), 32'h0);
    tick();
    check("t6_serr",  32'(c_serr), 32'h1);
    check("t6_valid", 32'(c_vo), 32'h0);
    c_sel = 2'd1; c_valid = 3'b010;
    #1;
    check("t6_grant1", 32'(c_grant), 32'h2);
    tick();
    check("t6_serr_clr", 32'(c_serr), 32'h0);
    check("t6_valid1",   32'(c_vo), 32'h1);
    check("t6_out1",     c_out, 32'hC1C1C1C1);
    c_sel = 2'd3;
    tick();
    check("t6_serr_again", 32'(c_serr), 32'h1);

    // Asynchronous reset mid-cycle, then RR restarts at channel 0
    b_valid = 4'b1111;
    #3;
    reset = 1'b0;
    #1;
    check("rst2_a_out",   a_out, 32'h0);
    check("rst2_a_valid", 32'(a_vo), 32'h0);
    check("rst2_b_chan",  32'(b_chan), 32'h0);
    check("rst2_b_grant", 32'(b_grant), 32'h0);
    check("rst2_c_serr",  32'(c_serr), 32'h0);
    check("rst2_c_out",   c_out, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    check("rst2_rr_restart", 32'(b_grant), 32'h1);
    tick();
    check("rst2_rr_chan", 32'(b_chan), 32'h0);
    check("rst2_rr_out",  b_out, 32'hB0000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
